// File: rtl/key_debounce.sv
// key_debounce: conditions a raw, bouncing, active-low push-button input.
// The key is synchronised through two flops (s1, s2) and qualified by a
// stable-count debouncer. Outputs a clean active-low level plus single-cycle
// press, release and long-press events and a wrapping press counter.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   key_in        raw button input, active-low, asynchronous to clk
//   key_n         debounced level, active-low (0 = pressed)
//   press_pulse   one-cycle pulse when a press is accepted
//   release_pulse one-cycle pulse when a release is accepted
//   long_pulse    one-cycle pulse when a hold lasts LONG_PRESS cycles
//   press_cnt     count of accepted presses, wraps 255 -> 0
module key_debounce #(
  parameter int unsigned DEBOUNCE   = 1000,
  parameter int unsigned LONG_PRESS = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       key_n,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  localparam logic [31:0] DEB_LAST  = 32'(DEBOUNCE - 1);
  localparam logic [31:0] HOLD_LAST = 32'(LONG_PRESS - 1);
  // Parking value once long_pulse has fired, so it fires once per press.
  localparam logic [31:0] HOLD_DONE = 32'(LONG_PRESS);

  state_t      state, state_nx;
  logic        s1, s2;
  logic [31:0] deb_cnt, deb_cnt_nx;
  logic [31:0] hold_cnt, hold_cnt_nx;
  logic        key_n_nx, press_nx, release_nx, long_nx;
  logic [7:0]  press_cnt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1            <= 1'b1;
      s2            <= 1'b1;
      state         <= IDLE;
      deb_cnt       <= '0;
      hold_cnt      <= '0;
      key_n         <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_cnt     <= '0;
    end else begin
      s1            <= key_in;
      s2            <= s1;
      state         <= state_nx;
      deb_cnt       <= deb_cnt_nx;
      hold_cnt      <= hold_cnt_nx;
      key_n         <= key_n_nx;
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      long_pulse    <= long_nx;
      press_cnt     <= press_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    deb_cnt_nx   = deb_cnt;
    hold_cnt_nx  = hold_cnt;
    key_n_nx     = key_n;
    press_nx     = 1'b0;
    release_nx   = 1'b0;
    long_nx      = 1'b0;
    press_cnt_nx = press_cnt;

    // Hold timer keeps running through release qualification, so a release
    // bounce does not lose accumulated hold time.
    if (state == HELD || state == RELEASE_CHK) begin
      if (hold_cnt < HOLD_LAST) begin
        hold_cnt_nx = hold_cnt + 32'd1;
      end else if (hold_cnt == HOLD_LAST) begin
        long_nx     = 1'b1;
        hold_cnt_nx = HOLD_DONE;
      end
    end

    case (state)
      IDLE: begin
        if (!s2) begin
          state_nx   = PRESS_CHK;
          deb_cnt_nx = '0;
        end
      end
      PRESS_CHK: begin
        if (s2) begin
          state_nx = IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_nx     = HELD;
          key_n_nx     = 1'b0;
          press_nx     = 1'b1;
          press_cnt_nx = press_cnt + 8'd1;
          hold_cnt_nx  = '0;
        end else begin
          deb_cnt_nx = deb_cnt + 32'd1;
        end
      end
      HELD: begin
        if (s2) begin
          state_nx   = RELEASE_CHK;
          deb_cnt_nx = '0;
        end
      end
      RELEASE_CHK: begin
        if (!s2) begin
          state_nx = HELD;
        end else if (deb_cnt == DEB_LAST) begin
          // long_nx from the hold timer above may coincide with this release.
          state_nx    = IDLE;
          key_n_nx    = 1'b1;
          release_nx  = 1'b1;
          hold_cnt_nx = '0;
        end else begin
          deb_cnt_nx = deb_cnt + 32'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (DEBOUNCE=4, LONG_PRESS=16). Expected
// pulse events (kind, edge index, press count) are queued when stimulus is
// driven and checked by a monitor when pulses appear on the outputs.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic       key_n;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_cnt;

  key_debounce #(
    .DEBOUNCE  (4),
    .LONG_PRESS(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_n        (key_n),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_cnt    (press_cnt)
  );

  always #5 clk = ~clk;

  // cyc == n after the n-th rising edge
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;  // 0 press, 1 release, 2 long
    int unsigned at;
    logic [7:0]  cnt;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] exp_cnt;
  int         n_cmp = 0;
  int         n_bad = 0;
  int unsigned a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int unsigned at);
    ev_t e;
    if (kind == 0) exp_cnt = exp_cnt + 8'd1;
    e.kind = kind;
    e.at   = at;
    e.cnt  = exp_cnt;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic handle(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      check("unexpected_pulse_kind", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      check("ev_kind", 32'(kind), 32'(e.kind));
      check("ev_cycle", cyc, e.at);
      if (kind == 0) begin
        check("press_key_n", {31'b0, key_n}, 32'd0);
        check("press_cnt_at_pulse", {24'b0, press_cnt}, {24'b0, e.cnt});
      end
      if (kind == 1) check("release_key_n", {31'b0, key_n}, 32'd1);
    end
  endtask

  // Monitor: pops expected events as pulses appear; flags overdue events.
  always @(negedge clk) begin
    if (press_pulse)   handle(0);
    if (release_pulse) handle(1);
    if (long_pulse)    handle(2);
    while (sb.size() > 0 && sb[0].at < cyc) begin
      check("missed_event_cycle", cyc, sb[0].at);
      void'(sb.pop_front());
    end
  end

  initial begin
    rst     = 1'b1;
    key_in  = 1'b1;
    exp_cnt = '0;
    tick(3);
    rst = 1'b0;

    // Released and idle
    for (int i = 0; i < 50; i++) begin
      tick(1);
      check("idle_key_n", {31'b0, key_n}, 32'd1);
      check("idle_cnt", {24'b0, press_cnt}, 32'd0);
      check("idle_pulses", {29'b0, press_pulse, release_pulse, long_pulse}, 32'd0);
    end

    // Clean press, quick clean release
    key_in = 1'b0;
    push(0, cyc + 7);
    tick(8);
    check("clean_key_n", {31'b0, key_n}, 32'd0);
    check("clean_cnt", {24'b0, press_cnt}, {24'b0, exp_cnt});
    key_in = 1'b1;
    push(1, cyc + 7);
    tick(10);
    check("clean_rel_key_n", {31'b0, key_n}, 32'd1);

    // Bouncy press, then hold 30 cycles past accept and release
    key_in = 1'b0; tick(1);
    key_in = 1'b1; tick(2);
    key_in = 1'b0; tick(1);
    key_in = 1'b1; tick(2);
    key_in = 1'b0;
    a = cyc + 7;
    push(0, a);
    push(2, a + 16);
    tick(int'(a + 30 - cyc));
    check("held_key_n", {31'b0, key_n}, 32'd0);
    key_in = 1'b1;
    push(1, cyc + 7);
    tick(10);
    check("hold_rel_key_n", {31'b0, key_n}, 32'd1);

    // Clear count, then 256 press/release cycles to wrap press_cnt
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_cnt = '0;
    check("pre_wrap_cnt", {24'b0, press_cnt}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      key_in = 1'b0;
      push(0, cyc + 7);
      tick(8);
      key_in = 1'b1;
      push(1, cyc + 7);
      tick(8);
    end
    check("wrap_cnt", {24'b0, press_cnt}, {24'b0, exp_cnt});

    // Reset while HELD with key still low
    key_in = 1'b0;
    push(0, cyc + 7);
    tick(10);
    check("pre_rst_key_n", {31'b0, key_n}, 32'd0);
    rst = 1'b1;
    tick(1);
    exp_cnt = '0;
    check("rst_key_n", {31'b0, key_n}, 32'd1);
    check("rst_cnt", {24'b0, press_cnt}, 32'd0);
    check("rst_pulses", {29'b0, press_pulse, release_pulse, long_pulse}, 32'd0);
    rst = 1'b0;
    push(0, cyc + 7);
    tick(9);
    check("repress_key_n", {31'b0, key_n}, 32'd0);
    check("repress_cnt", {24'b0, press_cnt}, {24'b0, exp_cnt});
    key_in = 1'b1;
    push(1, cyc + 7);
    tick(10);

    for (int i = 0; i < 40 && sb.size() > 0; i++) tick(1);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
# key_debounce

Front-end conditioning stage for the board push-buttons. It synchronises a raw, bouncing, active-low key input into the clock domain and filters it with a stable-count debouncer. It drives a clean active-low level straight into the start/LED controller, which treats 0 as pressed. It also produces single-cycle press, release and long-press events, plus a wrapping press counter for status display.

## Interface
- DEBOUNCE, default 1000: number of consecutive identical synchronised samples needed to accept a level change. Legal range is 1 to 2^32-1.
- LONG_PRESS, default 50000000: cycles spent in HELD before long_pulse fires. Legal range is 1 to 2^32-1.

Ports:
- clk  in  1  system clock. This is the only clock: one clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- key_in  in  1  raw button input, active-low, asynchronous to clk.
- key_n  out  1  debounced level, active-low (0 = pressed). Reset value 1.
- press_pulse  out  1  one-cycle pulse when a press is accepted. Reset value 0.
- release_pulse  out  1  one-cycle pulse when a release is accepted. Reset value 0.
- long_pulse  out  1  one-cycle pulse when a hold lasts LONG_PRESS cycles. Reset value 0.
- press_cnt  out  8  count of accepted presses, wraps from 255 to 0. Reset value 0.

## Operation
- Synchroniser: two flops, s1 then s2, both reset to 1 (released). The FSM and counters look only at s2.
- Debounce counter: 32-bit, deb_cnt. Hold counter: 32-bit, hold_cnt, saturating.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: released and stable.
    - If s2 = 0, go to PRESS_CHK and set deb_cnt to 0.
  - PRESS_CHK:
    - If s2 = 1 (bounce), go back to IDLE with no event.
    - Else if deb_cnt = DEBOUNCE-1, go to HELD. On the same edge: key_n becomes 0, press_pulse becomes 1, press_cnt increments, hold_cnt is set to 0.
    - Else deb_cnt increments.
  - HELD:
    - hold_cnt increments while below LONG_PRESS-1. When it reaches LONG_PRESS-1, long_pulse becomes 1 for one cycle and hold_cnt saturates, so long_pulse fires exactly once per press.
    - If s2 = 1, go to RELEASE_CHK and set deb_cnt to 0.
  - RELEASE_CHK:
    - If s2 = 0 (bounce), return to HELD with no event. hold_cnt is kept, not cleared, and keeps counting in both HELD and RELEASE_CHK.
    - Else if deb_cnt = DEBOUNCE-1, go to IDLE. On the same edge: key_n becomes 1, release_pulse becomes 1, hold_cnt is cleared.
    - Else deb_cnt increments.
- Pulses are cleared on every edge where they are not being set. No two pulses can be 1 in the same cycle, except that long_pulse and release_pulse may coincide if hold_cnt reaches its terminal value on the accepting release edge.
- Reset mid-operation:
  - Every register returns to its reset value and the FSM goes to IDLE.
  - A key still held after reset is re-qualified from scratch and counted as a new press.
  - No release_pulse is generated for a press that reset interrupted.

## Timing
- Let E0 be the first edge that samples key_in = 0 into s1, with key_in stable low afterwards.
  - s2 = 0 after E1.
  - IDLE→PRESS_CHK at E2.
  - key_n falls and press_pulse rises at edge E(DEBOUNCE+2), and press_pulse is 1 for exactly one cycle.
- Release has the same latency: DEBOUNCE+2 edges from the first sample of key_in = 1 to key_n rising and release_pulse.
- Any single-cycle glitch on s2 during a CHK state restarts qualification. The next attempt counts DEBOUNCE fresh samples.
- long_pulse fires LONG_PRESS edges after the press-accept edge, provided no release is accepted first.
- press_cnt updates on the same edge as press_pulse.

## Test plan
(All directed scenarios use DEBOUNCE=4 and LONG_PRESS=16.)
- Reset, then key_in held at 1 for 50 cycles: key_n = 1, all pulses 0, press_cnt = 0 throughout.
- Clean press, key_in falls before E0 and stays low: key_n falls after E6, press_pulse = 1 only in the cycle after E6, press_cnt = 1.
- Bouncy press, low-high-low-high at 1-2 cycle spacing, then stable low: no pulse during bouncing. key_n falls exactly 6 edges after the last falling-edge sample. Exactly one press_pulse.
- Hold for 30 cycles after accept, then release cleanly: long_pulse once, 16 edges after the press accept. release_pulse and key_n = 1 six edges after the release sample.
- 256 clean press/release cycles: press_cnt wraps to 0 on the 256th press_pulse.
- Assert rst for one cycle while in HELD with key_in still low: outputs return to reset values, no release_pulse. A new press_pulse follows 6 edges after reset deasserts, and press_cnt = 1.
